mini_bus_arbiter: RTL and testbench

//   Shares one memory bus between two requesters: the i-cache miss port (bus_ir_*) and a data port (bus_d_*).

---
 rtl/mini_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mini_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_bus_arbiter.sv
// mini_bus_arbiter: shares one memory bus between the i-cache miss port (bus_ir_*)
// and the data port (bus_d_*). One address beat then one data beat per transaction,
// round-robin arbitration, grant held from arbitration until the owner takes its data.
module mini_bus_arbiter #(
  parameter int data_width     = 32,
  parameter int addr_width     = 32,
  parameter int timeout_cycles = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_ir_addr_valid,
  output logic                  bus_ir_addr_ready,
  input  logic [addr_width-1:0] bus_ir_addr,
  output logic                  bus_ir_data_valid,
  input  logic                  bus_ir_data_ready,
  output logic [data_width-1:0] bus_ir_data,
  input  logic                  bus_d_addr_valid,
  output logic                  bus_d_addr_ready,
  input  logic [addr_width-1:0] bus_d_addr,
  output logic                  bus_d_data_valid,
  input  logic                  bus_d_data_ready,
  output logic [data_width-1:0] bus_d_data,
  output logic                  mem_addr_valid,
  input  logic                  mem_addr_ready,
  output logic [addr_width-1:0] mem_addr,
  input  logic                  mem_data_valid,
  output logic                  mem_data_ready,
  input  logic [data_width-1:0] mem_data,
  output logic                  grant_ir,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter is wide enough to hold timeout_cycles itself so it can saturate there.
  localparam int cnt_w = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(timeout_cycles);

  state_t           state;
  logic             owner_d;     // 0 = i-cache port owns the bus, 1 = data port
  logic             last_d;      // port that completed the most recent transaction
  logic [cnt_w-1:0] wd_count;
  logic             owner_data_ready;

  assign owner_data_ready = owner_d ? bus_d_data_ready : bus_ir_data_ready;
  assign grant_ir         = (state != IDLE) && !owner_d;

  // Arbitration FSM, round-robin history and RESP watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      last_d      <= 1'b1;
      wd_count    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_ir_addr_valid || bus_d_addr_valid) begin
            state <= ADDR;
            if (bus_ir_addr_valid && bus_d_addr_valid) owner_d <= ~last_d;
            else                                        owner_d <= bus_d_addr_valid;
          end
        end
        ADDR: begin
          if (mem_addr_ready) begin
            state    <= RESP;
            wd_count <= '0;
          end
        end
        RESP: begin
          if (mem_data_valid && owner_data_ready) begin
            state  <= IDLE;
            last_d <= owner_d;
          end
          if (timeout_cycles != 0) begin
            if (wd_count != cnt_max) wd_count <= wd_count + cnt_w'(1);
            else                     err_timeout <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner's address/data handshakes to memory; everything else stays quiet.
  always_comb begin
    mem_addr_valid    = 1'b0;
    mem_addr          = '0;
    mem_data_ready    = 1'b0;
    bus_ir_addr_ready = 1'b0;
    bus_d_addr_ready  = 1'b0;
    bus_ir_data_valid = 1'b0;
    bus_ir_data       = '0;
    bus_d_data_valid  = 1'b0;
    bus_d_data        = '0;
    case (state)
      ADDR: begin
        mem_addr_valid = 1'b1;
        if (owner_d) begin
          mem_addr         = bus_d_addr;
          bus_d_addr_ready = mem_addr_ready;
        end else begin
          mem_addr          = bus_ir_addr;
          bus_ir_addr_ready = mem_addr_ready;
        end
      end
      RESP: begin
        mem_data_ready = owner_data_ready;
        if (owner_d) begin
          bus_d_data_valid = mem_data_valid;
          bus_d_data       = mem_data;
        end else begin
          bus_ir_data_valid = mem_data_valid;
          bus_ir_data       = mem_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mini_bus_arbiter.sv
// tb_mini_bus_arbiter: directed vector table for the single-transaction cases plus
// hand-written sequences for round-robin, stalls, reset mid-RESP and the watchdog.
module tb_mini_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_ir_addr_valid, bus_ir_addr_ready;
  logic [31:0] bus_ir_addr;
  logic        bus_ir_data_valid, bus_ir_data_ready;
  logic [31:0] bus_ir_data;
  logic        bus_d_addr_valid, bus_d_addr_ready;
  logic [31:0] bus_d_addr;
  logic        bus_d_data_valid, bus_d_data_ready;
  logic [31:0] bus_d_data;
  logic        mem_addr_valid, mem_addr_ready;
  logic [31:0] mem_addr;
  logic        mem_data_valid, mem_data_ready;
  logic [31:0] mem_data;
  logic        grant_ir, err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int addr_hs      = 0;
  int data_hs      = 0;

  mini_bus_arbiter #(.data_width(32), .addr_width(32), .timeout_cycles(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_ir_addr_valid(bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready),
    .bus_ir_addr(bus_ir_addr), .bus_ir_data_valid(bus_ir_data_valid),
    .bus_ir_data_ready(bus_ir_data_ready), .bus_ir_data(bus_ir_data),
    .bus_d_addr_valid(bus_d_addr_valid), .bus_d_addr_ready(bus_d_addr_ready),
    .bus_d_addr(bus_d_addr), .bus_d_data_valid(bus_d_data_valid),
    .bus_d_data_ready(bus_d_data_ready), .bus_d_data(bus_d_data),
    .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready),
    .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
    .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .grant_ir(grant_ir), .err_timeout(err_timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count memory-side handshakes to catch lost or duplicated beats.
  always @(posedge clk) begin
    if (mem_addr_valid && mem_addr_ready) addr_hs++;
    if (mem_data_valid && mem_data_ready) data_hs++;
  end

  typedef struct {
    logic        rst;
    logic        ir_av;
    logic [31:0] ir_addr;
    logic        d_av;
    logic [31:0] d_addr;
    logic        mem_ar;
    logic        mem_dv;
    logic [31:0] mem_dat;
    logic        ir_dr;
    logic        d_dr;
    logic        e_mem_av;
    logic [31:0] e_mem_addr;
    logic        e_ir_ar;
    logic        e_d_ar;
    logic        e_ir_dv;
    logic [31:0] e_ir_data;
    logic        e_d_dv;
    logic [31:0] e_d_data;
    logic        e_mem_dr;
    logic        e_grant;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    bus_ir_addr_valid = 0; bus_ir_addr = 0; bus_ir_data_ready = 0;
    bus_d_addr_valid  = 0; bus_d_addr  = 0; bus_d_data_ready  = 0;
    mem_addr_ready    = 0; mem_data_valid = 0; mem_data = 0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus_ir_addr_valid = v.ir_av;  bus_ir_addr = v.ir_addr; bus_ir_data_ready = v.ir_dr;
    bus_d_addr_valid  = v.d_av;   bus_d_addr  = v.d_addr;  bus_d_data_ready  = v.d_dr;
    mem_addr_ready    = v.mem_ar; mem_data_valid = v.mem_dv; mem_data = v.mem_dat;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, " mem_addr_valid"}, mem_addr_valid, 0);
    check_output({tag, " mem_addr"}, mem_addr, 0);
    check_output({tag, " mem_data_ready"}, mem_data_ready, 0);
    check_output({tag, " ir_addr_ready"}, bus_ir_addr_ready, 0);
    check_output({tag, " ir_data_valid"}, bus_ir_data_valid, 0);
    check_output({tag, " ir_data"}, bus_ir_data, 0);
    check_output({tag, " d_addr_ready"}, bus_d_addr_ready, 0);
    check_output({tag, " d_data_valid"}, bus_d_data_valid, 0);
    check_output({tag, " d_data"}, bus_d_data, 0);
    check_output({tag, " grant_ir"}, grant_ir, 0);
  endtask

  initial begin
    int base_a;
    int base_d;
    int waited;
    logic exp_ir;

    rst_n = 1'b1;
    idle_inputs();

    // rst, ir_av, ir_addr, d_av, d_addr, mem_ar, mem_dv, mem_data, ir_dr, d_dr |
    // mem_av, mem_addr, ir_ar, d_ar, ir_dv, ir_data, d_dv, d_data, mem_dr, grant
    vecs[0]  = '{1, 1, 123, 0, 0, 1, 1, 101, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 123, 0, 0, 1, 1, 101, 1, 0,   1, 123, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 1, 1, 101, 1, 0,     0, 0, 0, 0, 1, 101, 0, 0, 1, 1};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 'h10, 1, 'h20, 1, 1, 'hA, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 'h10, 1, 'h20, 1, 1, 'hA, 1, 1, 1, 'h10, 1, 0, 0, 0, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 0, 1, 'h20, 1, 1, 'hA, 1, 1,    0, 0, 0, 0, 1, 'hA, 0, 0, 1, 1};
    vecs[7]  = '{0, 0, 0, 1, 'h20, 1, 1, 'hB, 1, 1,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 1, 'h20, 1, 1, 'hB, 1, 1,    1, 'h20, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 1, 1, 'hB, 1, 1,       0, 0, 0, 0, 0, 0, 1, 'hB, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    tick();

    // Single IR transaction and simultaneous IR/D requests, cycle by cycle.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst) do_reset();
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("row%0d mem_addr_valid", i), mem_addr_valid, vecs[i].e_mem_av);
      check_output($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      check_output($sformatf("row%0d ir_addr_ready", i), bus_ir_addr_ready, vecs[i].e_ir_ar);
      check_output($sformatf("row%0d d_addr_ready", i), bus_d_addr_ready, vecs[i].e_d_ar);
      check_output($sformatf("row%0d ir_data_valid", i), bus_ir_data_valid, vecs[i].e_ir_dv);
      check_output($sformatf("row%0d ir_data", i), bus_ir_data, vecs[i].e_ir_data);
      check_output($sformatf("row%0d d_data_valid", i), bus_d_data_valid, vecs[i].e_d_dv);
      check_output($sformatf("row%0d d_data", i), bus_d_data, vecs[i].e_d_data);
      check_output($sformatf("row%0d mem_data_ready", i), mem_data_ready, vecs[i].e_mem_dr);
      check_output($sformatf("row%0d grant_ir", i), grant_ir, vecs[i].e_grant);
      check_output($sformatf("row%0d err_timeout", i), err_timeout, 0);
      tick();
    end

    // Round-robin with both requesters continuously valid.
    idle_inputs();
    do_reset();
    bus_ir_addr_valid = 1; bus_ir_addr = 'h100; bus_ir_data_ready = 1;
    bus_d_addr_valid  = 1; bus_d_addr  = 'h200; bus_d_data_ready  = 1;
    mem_addr_ready = 1; mem_data_valid = 1; mem_data = 'h300;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_ir = (t % 2 == 0);
      waited = 0;
      while (!mem_addr_valid && waited < 8) begin
        tick();
        waited++;
      end
      check_output($sformatf("rr%0d addr wait within bound", t), mem_addr_valid, 1);
      check_output($sformatf("rr%0d grant_ir", t), grant_ir, exp_ir);
      check_output($sformatf("rr%0d mem_addr", t), mem_addr, exp_ir ? 'h100 : 'h200);
      tick();
      check_output($sformatf("rr%0d ir_data_valid", t), bus_ir_data_valid, exp_ir);
      check_output($sformatf("rr%0d d_data_valid", t), bus_d_data_valid, !exp_ir);
      tick();
    end

    // Address stall then data-ready stall: one beat each way, address held.
    idle_inputs();
    do_reset();
    base_a = addr_hs;
    base_d = data_hs;
    bus_ir_addr_valid = 1; bus_ir_addr = 'h44;
    tick();
    for (int s = 0; s < 5; s++) begin
      check_output($sformatf("stall%0d mem_addr_valid", s), mem_addr_valid, 1);
      check_output($sformatf("stall%0d mem_addr", s), mem_addr, 'h44);
      check_output($sformatf("stall%0d ir_addr_ready", s), bus_ir_addr_ready, 0);
      tick();
    end
    mem_addr_ready = 1;
    #1;
    check_output("stall ir_addr_ready", bus_ir_addr_ready, 1);
    tick();
    mem_addr_ready = 0; bus_ir_addr_valid = 0;
    mem_data_valid = 1; mem_data = 'h55;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_output($sformatf("dstall%0d ir_data_valid", s), bus_ir_data_valid, 1);
      check_output($sformatf("dstall%0d ir_data", s), bus_ir_data, 'h55);
      check_output($sformatf("dstall%0d mem_data_ready", s), mem_data_ready, 0);
      tick();
    end
    bus_ir_data_ready = 1;
    #1;
    check_output("dstall mem_data_ready", mem_data_ready, 1);
    tick();
    mem_data_valid = 0; bus_ir_data_ready = 0;
    #1;
    check_output("stall addr handshakes", addr_hs - base_a, 1);
    check_output("stall data handshakes", data_hs - base_d, 1);
    check_output("stall back to idle", mem_addr_valid, 0);

    // Reset pulsed while in RESP, then a normal transaction.
    idle_inputs();
    do_reset();
    bus_ir_addr_valid = 1; bus_ir_addr = 'h77; mem_addr_ready = 1; bus_ir_data_ready = 1;
    tick();
    tick();
    bus_ir_addr_valid = 0; mem_addr_ready = 0;
    #1;
    check_output("rst grant in RESP", grant_ir, 1);
    rst_n = 1'b0;
    mem_data_valid = 1; mem_data = 'h99;
    #1;
    check_zero_outputs("rst async");
    tick();
    check_zero_outputs("rst held");
    rst_n = 1'b1;
    mem_data_valid = 0;
    base_d = data_hs;
    bus_ir_addr_valid = 1; bus_ir_addr = 'h78; mem_addr_ready = 1;
    mem_data_valid = 1; mem_data = 'h79;
    tick();
    check_output("post-rst mem_addr", mem_addr, 'h78);
    tick();
    bus_ir_addr_valid = 0;
    #1;
    check_output("post-rst ir_data_valid", bus_ir_data_valid, 1);
    check_output("post-rst ir_data", bus_ir_data, 'h79);
    tick();
    check_output("post-rst data handshakes", data_hs - base_d, 1);
    check_output("post-rst idle", bus_ir_data_valid, 0);

    // Watchdog: memory silent in RESP, err_timeout rises and sticks.
    idle_inputs();
    do_reset();
    bus_ir_addr_valid = 1; bus_ir_addr = 'h66; mem_addr_ready = 1; bus_ir_data_ready = 1;
    tick();
    tick();
    bus_ir_addr_valid = 0; mem_addr_ready = 0;
    for (int c = 0; c < 5; c++) tick();
    check_output("wd early err_timeout", err_timeout, 0);
    for (int c = 0; c < 7; c++) tick();
    check_output("wd late err_timeout", err_timeout, 1);
    check_output("wd still granted", grant_ir, 1);
    mem_data_valid = 1; mem_data = 'h6A;
    #1;
    check_output("wd late ir_data_valid", bus_ir_data_valid, 1);
    check_output("wd late ir_data", bus_ir_data, 'h6A);
    tick();
    mem_data_valid = 0;
    #1;
    check_output("wd idle after reply", grant_ir, 0);
    tick();
    check_output("wd sticky err_timeout", err_timeout, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
